// File: rtl/csr_mmode_unit.sv
// Machine-mode CSR file and trap controller for the execute stage.
module csr_mmode_unit #(
  parameter int unsigned XLEN       = 32,
  parameter logic [31:0] HART_ID    = 32'h0,
  parameter logic [31:0] TVEC_RESET = 32'h0,
  parameter bit          VECTORED   = 1'b1,
  parameter bit          COUNTERS   = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_csr_en,
  input  logic [2:0]      i_funct3,
  input  logic [11:0]     i_addr,
  input  logic [XLEN-1:0] i_wd,
  input  logic            i_src_zero,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_badaddr,
  input  logic            i_ex_illegal,
  input  logic            i_ex_inst_addr,
  input  logic            i_ex_ld_addr,
  input  logic            i_ex_st_addr,
  input  logic            i_irq_sw,
  input  logic            i_irq_timer,
  input  logic            i_irq_ext,
  input  logic            i_instret,
  output logic [XLEN-1:0] o_rd,
  output logic            o_trap,
  output logic            o_eret,
  output logic [XLEN-1:0] o_target,
  output logic [XLEN-1:0] o_cause
);

  localparam int unsigned CW = XLEN - 1;
  localparam logic [11:0] A_MSTATUS = 12'h300, A_MISA = 12'h301, A_MIE = 12'h304;
  localparam logic [11:0] A_MTVEC = 12'h305, A_MSCRATCH = 12'h340, A_MEPC = 12'h341;
  localparam logic [11:0] A_MCAUSE = 12'h342, A_MTVAL = 12'h343, A_MIP = 12'h344;
  localparam logic [11:0] A_MCYCLE = 12'hB00, A_MCYCLEH = 12'hB80;
  localparam logic [11:0] A_MINSTRET = 12'hB02, A_MINSTRETH = 12'hB82, A_MHARTID = 12'hF14;
  localparam logic [XLEN-1:0] MIE_MASK = XLEN'(32'h0000_0888);
  localparam logic [XLEN-1:0] MISA_VAL = XLEN'(32'h4000_0100);

  logic            st_mie, st_mpie;
  logic [XLEN-1:0] mie_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-3:0] tvec_base;
  logic            tvec_mode;
  logic [63:0]     cycle_q, instret_q, cycle_nx, instret_nx;

  logic            is_priv, is_csr, is_ecall, is_ebreak, is_mret, priv_bad, bad_f3;
  logic            csr_wr, csr_hit, csr_illegal, illegal, wr_ok;
  logic [XLEN-1:0] rdata, wdata, mip, pend, mstatus_rd, vec_base;
  logic            exc, exc_tval, irq_take, trap, eret;
  logic [3:0]      exc_code, irq_code;
  logic [XLEN-1:0] cause, target;

  // Instruction decode
  assign is_priv   = i_csr_en && (i_funct3 == 3'b000);
  assign is_csr    = i_csr_en && (i_funct3[1:0] != 2'b00);
  assign bad_f3    = i_csr_en && (i_funct3 == 3'b100);
  assign is_ecall  = is_priv && (i_addr == 12'h000);
  assign is_ebreak = is_priv && (i_addr == 12'h001);
  assign is_mret   = is_priv && (i_addr == 12'h302);
  assign priv_bad  = is_priv && !(is_ecall || is_ebreak || is_mret);
  assign csr_wr    = is_csr && ((i_funct3[1:0] == 2'b01) || !i_src_zero);

  assign mip        = {{(XLEN-12){1'b0}}, i_irq_ext, 3'b000, i_irq_timer, 3'b000, i_irq_sw, 3'b000};
  assign mstatus_rd = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, st_mpie, 3'b000, st_mie, 3'b000};
  assign vec_base   = {tvec_base, 2'b00};

  // CSR read mux
  always_comb begin
    rdata   = '0;
    csr_hit = 1'b1;
    case (i_addr)
      A_MSTATUS:   rdata = mstatus_rd;
      A_MISA:      rdata = MISA_VAL;
      A_MIE:       rdata = mie_q;
      A_MTVEC:     rdata = {tvec_base, 1'b0, tvec_mode};
      A_MSCRATCH:  rdata = mscratch_q;
      A_MEPC:      rdata = mepc_q;
      A_MCAUSE:    rdata = mcause_q;
      A_MTVAL:     rdata = mtval_q;
      A_MIP:       rdata = mip;
      A_MCYCLE:    rdata = cycle_q[31:0];
      A_MCYCLEH:   rdata = cycle_q[63:32];
      A_MINSTRET:  rdata = instret_q[31:0];
      A_MINSTRETH: rdata = instret_q[63:32];
      A_MHARTID:   rdata = HART_ID;
      default:     csr_hit = 1'b0;
    endcase
  end

  // Read-modify-write data
  always_comb begin
    case (i_funct3[1:0])
      2'b01:   wdata = i_wd;
      2'b10:   wdata = rdata | i_wd;
      2'b11:   wdata = rdata & ~i_wd;
      default: wdata = rdata;
    endcase
  end

  assign csr_illegal = is_csr && (!csr_hit || (csr_wr && (i_addr[11:10] == 2'b11)));
  assign illegal     = i_ex_illegal || csr_illegal || priv_bad || bad_f3;

  // Synchronous exception priority
  always_comb begin
    exc      = 1'b1;
    exc_tval = 1'b0;
    exc_code = 4'd0;
    if (i_ex_inst_addr) begin
      exc_code = 4'd0;
      exc_tval = 1'b1;
    end else if (illegal)   exc_code = 4'd2;
    else if (is_ebreak)     exc_code = 4'd3;
    else if (is_ecall)      exc_code = 4'd11;
    else if (i_ex_ld_addr) begin
      exc_code = 4'd4;
      exc_tval = 1'b1;
    end else if (i_ex_st_addr) begin
      exc_code = 4'd6;
      exc_tval = 1'b1;
    end else exc = 1'b0;
  end

  // Interrupt selection; only sampled on cycles carrying an instruction
  assign pend     = mip & mie_q & {XLEN{st_mie}};
  assign irq_take = !exc && (i_csr_en || i_instret) && (|pend);
  always_comb begin
    irq_code = 4'd7;
    if (pend[11])     irq_code = 4'd11;
    else if (pend[3]) irq_code = 4'd3;
  end

  assign trap  = exc || irq_take;
  assign eret  = is_mret && !trap;
  assign wr_ok = csr_wr && !trap;
  assign cause = irq_take ? {1'b1, CW'(irq_code)} : (exc ? XLEN'(exc_code) : '0);

  // Redirect target: vectored offset applies to interrupts only
  always_comb begin
    target = '0;
    if (trap) begin
      target = vec_base;
      if (irq_take && tvec_mode) target = vec_base + XLEN'({irq_code, 2'b00});
    end else if (eret) begin
      target = mepc_q;
    end
  end

  assign o_rd     = (i_rst_n && i_csr_en) ? rdata : '0;
  assign o_trap   = i_rst_n && trap;
  assign o_eret   = i_rst_n && eret;
  assign o_target = i_rst_n ? target : '0;
  assign o_cause  = (i_rst_n && trap) ? cause : '0;

  // Counter next values; a write to a half replaces that half's increment
  always_comb begin
    cycle_nx   = cycle_q + 64'd1;
    instret_nx = instret_q + ((i_instret && !trap) ? 64'd1 : 64'd0);
    if (wr_ok && (i_addr == A_MCYCLE))    cycle_nx[31:0]    = wdata;
    if (wr_ok && (i_addr == A_MCYCLEH))   cycle_nx[63:32]   = wdata;
    if (wr_ok && (i_addr == A_MINSTRET))  instret_nx[31:0]  = wdata;
    if (wr_ok && (i_addr == A_MINSTRETH)) instret_nx[63:32] = wdata;
  end

  // CSR state, trap/return side effects and counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      tvec_base  <= TVEC_RESET[XLEN-1:2];
      tvec_mode  <= VECTORED && TVEC_RESET[0];
      cycle_q    <= '0;
      instret_q  <= '0;
    end else begin
      if (COUNTERS) begin
        cycle_q   <= cycle_nx;
        instret_q <= instret_nx;
      end
      if (wr_ok) begin
        case (i_addr)
          A_MSTATUS: begin
            st_mie  <= wdata[3];
            st_mpie <= wdata[7];
          end
          A_MIE:      mie_q      <= wdata & MIE_MASK;
          A_MTVEC: begin
            tvec_base <= wdata[XLEN-1:2];
            tvec_mode <= VECTORED && wdata[0];
          end
          A_MSCRATCH: mscratch_q <= wdata;
          A_MEPC:     mepc_q     <= wdata & ~XLEN'(3);
          A_MCAUSE:   mcause_q   <= wdata;
          A_MTVAL:    mtval_q    <= wdata;
          default: ;
        endcase
      end
      if (trap) begin
        mepc_q   <= i_pc & ~XLEN'(3);
        mcause_q <= cause;
        mtval_q  <= (exc && exc_tval) ? i_badaddr : '0;
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
      end else if (eret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_csr_mmode_unit.sv
// Directed testbench for csr_mmode_unit.
module tb_csr_mmode_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_csr_en;
  logic [2:0]  i_funct3;
  logic [11:0] i_addr;
  logic [31:0] i_wd, i_pc, i_badaddr;
  logic        i_src_zero, i_ex_illegal, i_ex_inst_addr, i_ex_ld_addr, i_ex_st_addr;
  logic        i_irq_sw, i_irq_timer, i_irq_ext, i_instret;
  logic [31:0] o_rd, o_target, o_cause;
  logic        o_trap, o_eret;

  int checks = 0;
  int errors = 0;

  csr_mmode_unit #(
    .XLEN(32), .HART_ID(32'h5), .TVEC_RESET(32'h200), .VECTORED(1'b1), .COUNTERS(1'b1)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_csr_en(i_csr_en), .i_funct3(i_funct3),
    .i_addr(i_addr), .i_wd(i_wd), .i_src_zero(i_src_zero), .i_pc(i_pc),
    .i_badaddr(i_badaddr), .i_ex_illegal(i_ex_illegal), .i_ex_inst_addr(i_ex_inst_addr),
    .i_ex_ld_addr(i_ex_ld_addr), .i_ex_st_addr(i_ex_st_addr), .i_irq_sw(i_irq_sw),
    .i_irq_timer(i_irq_timer), .i_irq_ext(i_irq_ext), .i_instret(i_instret),
    .o_rd(o_rd), .o_trap(o_trap), .o_eret(o_eret), .o_target(o_target), .o_cause(o_cause)
  );

  always #5 i_clk = ~i_clk;

  task automatic idle();
    i_csr_en = 0; i_funct3 = 3'b000; i_addr = 12'h0; i_wd = 0; i_src_zero = 0;
    i_pc = 0; i_badaddr = 0; i_ex_illegal = 0; i_ex_inst_addr = 0; i_ex_ld_addr = 0;
    i_ex_st_addr = 0; i_irq_sw = 0; i_irq_timer = 0; i_irq_ext = 0; i_instret = 0;
  endtask

  // Advance one clock, then return inputs to idle
  task automatic next();
    @(posedge i_clk); #1;
    idle();
  endtask

  task automatic op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd, input logic z);
    i_csr_en = 1; i_funct3 = f3; i_addr = a; i_wd = wd; i_src_zero = z;
  endtask

  // Pure read: CSRRS with rs1 = x0
  task automatic rd(input logic [11:0] a);
    op(3'b010, a, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    idle(); i_rst_n = 0; rd(12'h305); i_ex_ld_addr = 1; i_badaddr = 32'hDEAD;
    repeat (3) @(negedge i_clk);
    checks++; if (o_rd !== 32'h0) begin errors++; $display("FAIL rst_rd got=%h exp=%h", o_rd, 32'h0); end
    checks++; if (o_trap !== 1'b0) begin errors++; $display("FAIL rst_trap got=%b exp=0", o_trap); end
    checks++; if (o_cause !== 32'h0) begin errors++; $display("FAIL rst_cause got=%h exp=0", o_cause); end
    @(posedge i_clk); #1; i_rst_n = 1; idle(); rd(12'hB00);
    @(negedge i_clk);
    checks++; if (o_rd !== 32'h0) begin errors++; $display("FAIL mcycle_rst got=%h exp=%h", o_rd, 32'h0); end
    next(); rd(12'h300); @(negedge i_clk);
    checks++; if (o_rd !== 32'h1800) begin errors++; $display("FAIL mstatus_rst got=%h exp=%h", o_rd, 32'h1800); end
    next(); rd(12'h305); @(negedge i_clk);
    checks++; if (o_rd !== 32'h200) begin errors++; $display("FAIL mtvec_rst got=%h exp=%h", o_rd, 32'h200); end
    repeat (8) next();
    rd(12'hB00); @(negedge i_clk);
    checks++; if (o_rd !== 32'd10) begin errors++; $display("FAIL mcycle_10 got=%h exp=%h", o_rd, 32'd10); end
  endtask

  task automatic test_trap_irq();
    next(); op(3'b001, 12'h305, 32'h101, 0); @(negedge i_clk);
    checks++; if (o_rd !== 32'h200) begin errors++; $display("FAIL csrrw_old got=%h exp=%h", o_rd, 32'h200); end
    next(); op(3'b010, 12'h304, 32'h80, 0);
    next(); op(3'b010, 12'h300, 32'h8, 0);
    next(); rd(12'h305); @(negedge i_clk);
    checks++; if (o_rd !== 32'h101) begin errors++; $display("FAIL mtvec_wr got=%h exp=%h", o_rd, 32'h101); end
    next(); i_irq_timer = 1; i_instret = 1; i_pc = 32'h80; @(negedge i_clk);
    checks++; if (o_trap !== 1'b1) begin errors++; $display("FAIL irq_trap got=%b exp=1", o_trap); end
    checks++; if (o_target !== 32'h11C) begin errors++; $display("FAIL irq_target got=%h exp=%h", o_target, 32'h11C); end
    checks++; if (o_cause !== 32'h80000007) begin errors++; $display("FAIL irq_cause got=%h exp=%h", o_cause, 32'h80000007); end
    next(); rd(12'h342); @(negedge i_clk);
    checks++; if (o_rd !== 32'h80000007) begin errors++; $display("FAIL mcause_irq got=%h exp=%h", o_rd, 32'h80000007); end
    next(); rd(12'h341); @(negedge i_clk);
    checks++; if (o_rd !== 32'h80) begin errors++; $display("FAIL mepc_irq got=%h exp=%h", o_rd, 32'h80); end
    next(); rd(12'h300); @(negedge i_clk);
    checks++; if (o_rd !== 32'h1880) begin errors++; $display("FAIL mstatus_trap got=%h exp=%h", o_rd, 32'h1880); end
  endtask

  task automatic test_mret();
    next(); op(3'b000, 12'h302, 32'h0, 0); @(negedge i_clk);
    checks++; if (o_eret !== 1'b1) begin errors++; $display("FAIL mret_eret got=%b exp=1", o_eret); end
    checks++; if (o_target !== 32'h80) begin errors++; $display("FAIL mret_target got=%h exp=%h", o_target, 32'h80); end
    next(); rd(12'h300); @(negedge i_clk);
    checks++; if (o_rd !== 32'h1888) begin errors++; $display("FAIL mstatus_mret got=%h exp=%h", o_rd, 32'h1888); end
  endtask

  task automatic test_exc_priority();
    next(); op(3'b000, 12'h000, 32'h0, 0); i_ex_ld_addr = 1; i_badaddr = 32'h1003; i_pc = 32'h104;
    @(negedge i_clk);
    checks++; if (o_cause !== 32'd11) begin errors++; $display("FAIL ecall_cause got=%h exp=%h", o_cause, 32'd11); end
    checks++; if (o_target !== 32'h100) begin errors++; $display("FAIL exc_target got=%h exp=%h", o_target, 32'h100); end
    next(); rd(12'h343); @(negedge i_clk);
    checks++; if (o_rd !== 32'h0) begin errors++; $display("FAIL ecall_mtval got=%h exp=%h", o_rd, 32'h0); end
    next(); rd(12'h341); @(negedge i_clk);
    checks++; if (o_rd !== 32'h104) begin errors++; $display("FAIL ecall_mepc got=%h exp=%h", o_rd, 32'h104); end
    next(); i_ex_ld_addr = 1; i_badaddr = 32'h1003; @(negedge i_clk);
    checks++; if (o_cause !== 32'd4) begin errors++; $display("FAIL ld_cause got=%h exp=%h", o_cause, 32'd4); end
    next(); rd(12'h343); @(negedge i_clk);
    checks++; if (o_rd !== 32'h1003) begin errors++; $display("FAIL ld_mtval got=%h exp=%h", o_rd, 32'h1003); end
    next(); i_ex_inst_addr = 1; i_ex_illegal = 1; @(negedge i_clk);
    checks++; if (o_cause !== 32'd0 || o_trap !== 1'b1) begin errors++; $display("FAIL iaddr_prio got=%h/%b exp=0/1", o_cause, o_trap); end
  endtask

  task automatic test_illegal();
    next(); op(3'b001, 12'hF14, 32'h99, 0); @(negedge i_clk);
    checks++; if (o_trap !== 1'b1 || o_cause !== 32'd2) begin errors++; $display("FAIL hartid_wr got=%b/%h exp=1/2", o_trap, o_cause); end
    next(); rd(12'hF14); @(negedge i_clk);
    checks++; if (o_trap !== 1'b0) begin errors++; $display("FAIL hartid_rd_trap got=%b exp=0", o_trap); end
    checks++; if (o_rd !== 32'h5) begin errors++; $display("FAIL hartid_val got=%h exp=%h", o_rd, 32'h5); end
    next(); rd(12'h7C0); @(negedge i_clk);
    checks++; if (o_cause !== 32'd2) begin errors++; $display("FAIL unmapped got=%h exp=%h", o_cause, 32'd2); end
  endtask

  task automatic test_back_to_back();
    next(); op(3'b001, 12'h340, 32'hA5, 0);
    next(); op(3'b001, 12'h340, 32'h5A, 0); i_ex_st_addr = 1; @(negedge i_clk);
    checks++; if (o_cause !== 32'd6 || o_rd !== 32'hA5) begin errors++; $display("FAIL st_trap got=%h/%h exp=6/a5", o_cause, o_rd); end
    next(); op(3'b011, 12'h340, 32'h0F, 0); @(negedge i_clk);
    checks++; if (o_rd !== 32'hA5) begin errors++; $display("FAIL write_dropped got=%h exp=%h", o_rd, 32'hA5); end
    next(); rd(12'h340); @(negedge i_clk);
    checks++; if (o_rd !== 32'hA0) begin errors++; $display("FAIL csrrc got=%h exp=%h", o_rd, 32'hA0); end
    next(); op(3'b001, 12'h341, 32'h123, 0);
    next(); rd(12'h341); @(negedge i_clk);
    checks++; if (o_rd !== 32'h120) begin errors++; $display("FAIL mepc_align got=%h exp=%h", o_rd, 32'h120); end
  endtask

  task automatic test_irq_priority();
    next(); op(3'b001, 12'h304, 32'h888, 0);
    next(); op(3'b010, 12'h300, 32'h8, 0);
    next(); i_irq_sw = 1; i_irq_timer = 1; @(negedge i_clk);
    checks++; if (o_trap !== 1'b0) begin errors++; $display("FAIL irq_unsampled got=%b exp=0", o_trap); end
    next(); i_irq_sw = 1; i_irq_timer = 1; i_instret = 1; @(negedge i_clk);
    checks++; if (o_cause !== 32'h80000003) begin errors++; $display("FAIL irq_prio got=%h exp=%h", o_cause, 32'h80000003); end
    checks++; if (o_target !== 32'h10C) begin errors++; $display("FAIL irq_vec got=%h exp=%h", o_target, 32'h10C); end
  endtask

  task automatic test_counters();
    next(); rd(12'hB02); @(negedge i_clk);
    checks++; if (o_rd !== 32'h0) begin errors++; $display("FAIL minstret_trap got=%h exp=%h", o_rd, 32'h0); end
    next(); i_instret = 1;
    next(); i_instret = 1;
    next(); rd(12'hB02); @(negedge i_clk);
    checks++; if (o_rd !== 32'h2) begin errors++; $display("FAIL minstret_cnt got=%h exp=%h", o_rd, 32'h2); end
    next(); op(3'b001, 12'hB80, 32'h0, 0);
    next(); op(3'b001, 12'hB00, 32'hFFFF_FFFF, 0);
    next(); rd(12'hB00); @(negedge i_clk);
    checks++; if (o_rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_wr got=%h exp=%h", o_rd, 32'hFFFF_FFFF); end
    next(); rd(12'hB00); @(negedge i_clk);
    checks++; if (o_rd !== 32'h0) begin errors++; $display("FAIL mcycle_wrap got=%h exp=%h", o_rd, 32'h0); end
    next(); rd(12'hB80); @(negedge i_clk);
    checks++; if (o_rd !== 32'h1) begin errors++; $display("FAIL mcycleh_carry got=%h exp=%h", o_rd, 32'h1); end
  endtask

  initial begin
    test_reset();
    test_trap_irq();
    test_mret();
    test_exc_priority();
    test_illegal();
    test_back_to_back();
    test_irq_priority();
    test_counters();
    next();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
